// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the fetch PC, issues single-outstanding
// memory reads and buffers returned instructions in a small FIFO toward decode.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        mem_req_valid,
    output logic [31:0] mem_req_addr,
    input  logic        mem_req_ready,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        out_ready,
    output logic        busy
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_WAIT    = 2'd2,
        S_DISCARD = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      fetch_pc_q;
    logic [31:0]      req_pc_q;
    logic [31:0]      instr_q [DEPTH];
    logic [31:0]      pc_q    [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_after_s;
    logic             accept_s;
    logic             push_s;
    logic             pop_s;
    logic             redirect_lsb_unused_s;

    assign redirect_lsb_unused_s = ^redirect_pc[1:0];

    // A response that coincides with a redirect belongs to the old path and is never pushed.
    assign accept_s      = (state_q == S_REQ) & mem_req_ready;
    assign push_s        = (state_q == S_WAIT) & mem_rsp_valid & ~redirect_valid;
    assign pop_s         = (count_q != {CNT_W{1'b0}}) & out_ready;
    assign count_after_s = count_q + CNT_W'(push_s) - CNT_W'(pop_s);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a redirect overrides the normal flow in every state.
    always_comb begin
        state_d = state_q;
        if (redirect_valid) begin
            case (state_q)
                S_IDLE:    state_d = S_REQ;
                S_REQ:     state_d = mem_req_ready ? S_DISCARD : S_REQ;
                S_WAIT:    state_d = mem_rsp_valid ? S_REQ : S_DISCARD;
                S_DISCARD: state_d = mem_rsp_valid ? S_REQ : S_DISCARD;
                default:   state_d = S_IDLE;
            endcase
        end else begin
            case (state_q)
                S_IDLE:    state_d = (count_q < DEPTH_C) ? S_REQ : S_IDLE;
                S_REQ:     state_d = mem_req_ready ? S_WAIT : S_REQ;
                S_WAIT: begin
                    if (mem_rsp_valid) begin
                        state_d = (count_after_s < DEPTH_C) ? S_REQ : S_IDLE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
                S_DISCARD: state_d = mem_rsp_valid ? S_REQ : S_DISCARD;
                default:   state_d = S_IDLE;
            endcase
        end
    end

    // Memory-side outputs derived from the state register.
    always_comb begin
        mem_req_valid = (state_q == S_REQ);
        mem_req_addr  = fetch_pc_q;
        busy          = (state_q != S_IDLE);
    end

    // Fetch PC, in-flight request PC and FIFO bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
            wr_ptr_q   <= {PTR_W{1'b0}};
            rd_ptr_q   <= {PTR_W{1'b0}};
            count_q    <= {CNT_W{1'b0}};
        end else begin
            if (redirect_valid) begin
                fetch_pc_q <= {redirect_pc[31:2], 2'b00};
            end else if (accept_s) begin
                fetch_pc_q <= fetch_pc_q + 32'd4;
            end
            if (accept_s) begin
                req_pc_q <= fetch_pc_q;
            end
            if (redirect_valid) begin
                wr_ptr_q <= {PTR_W{1'b0}};
                rd_ptr_q <= {PTR_W{1'b0}};
                count_q  <= {CNT_W{1'b0}};
            end else begin
                if (push_s) begin
                    wr_ptr_q <= wr_ptr_q + PTR_W'(1'b1);
                end
                if (pop_s) begin
                    rd_ptr_q <= rd_ptr_q + PTR_W'(1'b1);
                end
                count_q <= count_after_s;
            end
        end
    end

    // FIFO storage; contents are only observable through count_q, so no reset needed.
    always_ff @(posedge clk) begin
        if (push_s && !reset) begin
            instr_q[wr_ptr_q] <= mem_rsp_data;
            pc_q[wr_ptr_q]    <= req_pc_q;
        end
    end

    // Decode-side outputs: head entry, forced to zero while empty.
    always_comb begin
        out_valid = (count_q != {CNT_W{1'b0}});
        if (count_q != {CNT_W{1'b0}}) begin
            out_instr = instr_q[rd_ptr_q];
            out_pc    = pc_q[rd_ptr_q];
        end else begin
            out_instr = 32'h0000_0000;
            out_pc    = 32'h0000_0000;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus random traffic,
// checked every cycle against a transaction-level model (queue FIFO + request/owed flags).
module tb_fetch_sequencer;
    localparam logic [31:0] RPC   = 32'hFFFF_FFF8;
    localparam int          DEPTH = 2;

    logic        clk;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_ready;
    logic        busy;

    fetch_sequencer #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_req_valid  (mem_req_valid),
        .mem_req_addr   (mem_req_addr),
        .mem_req_ready  (mem_req_ready),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_ready      (out_ready),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: queued {instr, pc}, whether a request is presented, whether a response is owed and stale.
    logic [63:0] m_fifo[$];
    bit          m_req, m_out, m_stale, model_ok;
    logic [31:0] m_pc, m_req_pc;

    // Memory: one response per accept, mem_lat cycles later.
    int          rsp_cnt = 0;
    int          mem_lat = 1;
    logic [31:0] rsp_data;
    bit          fix_en;
    logic [31:0] fix_data;
    bit          inj_rsp;
    logic [31:0] inj_data;
    int          acc_cnt;
    int          ov_cnt;
    logic [31:0] acc_addrs[$];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_ne(string name, logic [31:0] act, logic [31:0] bad);
        n_checks++;
        if (act === bad) begin
            n_fail++;
            $display("FAIL %s: got %h which must not appear", name, act);
        end
    endtask

    function automatic logic [31:0] get_acc(int i);
        logic [31:0] v;
        v = 32'hxxxx_xxxx;
        if (i < acc_addrs.size()) v = acc_addrs[i];
        return v;
    endfunction

    task automatic model_edge(bit acc);
        bit rsp;
        bit pop;
        int sz0;
        if (reset) begin
            m_fifo.delete();
            m_req = 1'b0; m_out = 1'b0; m_stale = 1'b0;
            m_pc = RPC; m_req_pc = RPC;
            return;
        end
        rsp = m_out && mem_rsp_valid;
        pop = (m_fifo.size() != 0) && out_ready;
        sz0 = m_fifo.size();
        if (redirect_valid) begin
            m_fifo.delete();
            m_pc = {redirect_pc[31:2], 2'b00};
            if (acc || (m_out && !rsp)) begin
                m_req = 1'b0; m_out = 1'b1; m_stale = 1'b1;
            end else begin
                m_req = 1'b1; m_out = 1'b0; m_stale = 1'b0;
            end
        end else begin
            if (pop) void'(m_fifo.pop_front());
            if (rsp) begin
                if (!m_stale) m_fifo.push_back({mem_rsp_data, m_req_pc});
                m_req   = m_stale || (m_fifo.size() < DEPTH);
                m_out   = 1'b0;
                m_stale = 1'b0;
            end else if (acc) begin
                m_req    = 1'b0;
                m_out    = 1'b1;
                m_req_pc = m_pc;
                m_pc     = m_pc + 32'd4;
            end else if (!m_req && !m_out) begin
                m_req = (sz0 < DEPTH);
            end
        end
    endtask

    task automatic model_check();
        logic [31:0] ei, ep;
        ei = 32'h0;
        ep = 32'h0;
        if (m_fifo.size() != 0) begin
            ei = m_fifo[0][63:32];
            ep = m_fifo[0][31:0];
        end
        chk("mem_req_valid", 32'(mem_req_valid), 32'(m_req));
        chk("mem_req_addr",  mem_req_addr, m_pc);
        chk("out_valid",     32'(out_valid), 32'(m_fifo.size() != 0));
        chk("out_instr",     out_instr, ei);
        chk("out_pc",        out_pc, ep);
        chk("busy",          32'(busy), 32'(m_req || m_out));
    endtask

    // One clock: drive memory response, advance model at the edge, compare at the next negedge.
    task automatic step();
        bit acc;
        mem_rsp_valid = inj_rsp || (rsp_cnt == 1);
        if (inj_rsp) mem_rsp_data = inj_data;
        else if (rsp_cnt == 1) mem_rsp_data = rsp_data;
        else mem_rsp_data = $urandom;
        if (mem_req_valid && mem_req_ready) begin
            acc_cnt++;
            acc_addrs.push_back(mem_req_addr);
        end
        ov_cnt += (out_valid && out_ready) ? 1 : 0;
        acc = m_req && mem_req_ready;
        @(posedge clk);
        model_edge(acc);
        if (reset) begin
            model_ok = 1'b1;
            rsp_cnt  = 0;
        end else begin
            if (rsp_cnt > 0) rsp_cnt--;
            if (acc) begin
                rsp_cnt  = mem_lat;
                rsp_data = fix_en ? fix_data : $urandom;
            end
        end
        @(negedge clk);
        redirect_valid = 1'b0;
        inj_rsp        = 1'b0;
        if (model_ok) model_check();
    endtask

    task automatic wait_req(string name);
        for (int i = 0; i < 20 && !mem_req_valid; i++) step();
        chk(name, 32'(mem_req_valid), 32'd1);
    endtask

    task automatic wait_out(string name);
        for (int i = 0; i < 20 && !out_valid; i++) step();
        chk(name, 32'(out_valid), 32'd1);
    endtask

    task automatic chk_reset_vals(string tag);
        chk({tag, "_req_valid"}, 32'(mem_req_valid), 32'd0);
        chk({tag, "_req_addr"},  mem_req_addr, 32'hFFFF_FFF8);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_out_instr"}, out_instr, 32'h0);
        chk({tag, "_out_pc"},    out_pc, 32'h0);
        chk({tag, "_busy"},      32'(busy), 32'd0);
    endtask

    initial begin
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
        mem_req_ready = 1'b1; mem_rsp_valid = 1'b0; mem_rsp_data = 32'h0;
        out_ready = 1'b1; fix_en = 1'b0; fix_data = 32'h0; inj_rsp = 1'b0;
        inj_data = 32'h0; acc_cnt = 0; ov_cnt = 0; model_ok = 1'b0;
        m_req = 1'b0; m_out = 1'b0; m_stale = 1'b0; m_pc = RPC; m_req_pc = RPC;

        // Reset values, first request timing, address wrap and zero-wait throughput.
        step(); step();
        chk_reset_vals("rst");
        reset = 1'b0;
        acc_addrs.delete();
        step();
        chk("first_req_valid", 32'(mem_req_valid), 32'd1);
        chk("first_req_addr", mem_req_addr, 32'hFFFF_FFF8);
        repeat (10) step();
        chk("wrap_addr0", get_acc(0), 32'hFFFF_FFF8);
        chk("wrap_addr1", get_acc(1), 32'hFFFF_FFFC);
        chk("wrap_addr2", get_acc(2), 32'h0000_0000);
        chk("wrap_addr3", get_acc(3), 32'h0000_0004);
        ov_cnt = 0;
        repeat (20) step();
        chk("zero_wait_rate", 32'(ov_cnt), 32'd10);

        // Back-pressure: FIFO fills with exactly DEPTH entries, one pop lets exactly one request out.
        out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0;
        step();
        acc_cnt = 0;
        repeat (20) step();
        chk("bp_accepts", 32'(acc_cnt), 32'd2);
        chk("bp_idle_valid", 32'(mem_req_valid), 32'd0);
        chk("bp_idle_busy", 32'(busy), 32'd0);
        chk("bp_head_pc", out_pc, 32'h0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp_next_head_pc", out_pc, 32'h4);
        acc_cnt = 0;
        repeat (15) step();
        chk("bp_one_more", 32'(acc_cnt), 32'd1);

        // Stalled request holds address; fetch_pc advances only on accept.
        out_ready = 1'b1; mem_req_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", 32'(mem_req_valid), 32'd1);
            chk("stall_addr", mem_req_addr, 32'h40);
            step();
        end
        mem_req_ready = 1'b1;
        step();
        chk("post_accept_addr", mem_req_addr, 32'h44);
        chk("post_accept_valid", 32'(mem_req_valid), 32'd0);

        // Redirect in WAIT: the late DEADBEEF response is dropped.
        wait_req("wait_req_p4");
        mem_lat = 3; fix_en = 1'b1; fix_data = 32'hDEAD_BEEF;
        step();
        fix_en = 1'b0; mem_lat = 1;
        acc_addrs.delete();
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        step();
        wait_out("wait_out_p4");
        chk("redir_out_pc", out_pc, 32'h100);
        chk_ne("redir_out_instr", out_instr, 32'hDEAD_BEEF);
        chk("redir_req_addr", get_acc(0), 32'h100);

        // Redirect with full FIFO and a simultaneous pop.
        out_ready = 1'b0;
        for (int i = 0; i < 30 && !(!busy && out_valid); i++) step();
        chk("full_idle", 32'(!busy && out_valid), 32'd1);
        out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h203;
        step();
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_req_valid", 32'(mem_req_valid), 32'd1);
        chk("flush_req_addr", mem_req_addr, 32'h200);

        // Reset during WAIT; a response landing after reset is ignored.
        mem_lat = 3;
        wait_req("wait_req_p6");
        step();
        chk("p6_busy", 32'(busy), 32'd1);
        step();
        reset = 1'b1;
        step();
        chk_reset_vals("midrst");
        reset = 1'b0; inj_rsp = 1'b1; inj_data = 32'hBAD0_BAD0;
        step();
        chk("p6_req_valid", 32'(mem_req_valid), 32'd1);
        chk("p6_out_valid", 32'(out_valid), 32'd0);
        mem_lat = 1;
        wait_out("wait_out_p6");
        chk("p6_out_pc", out_pc, 32'hFFFF_FFF8);
        chk_ne("p6_out_instr", out_instr, 32'hBAD0_BAD0);

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            mem_req_ready = (($urandom % 10) < 7);
            out_ready     = (($urandom % 3) != 0);
            mem_lat       = int'($urandom_range(1, 4));
            if (($urandom % 25) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc    = $urandom;
            end
            reset = (($urandom % 400) == 0);
            step();
        end
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
